// File: rtl/lc3_seq_controller.sv
// LC-3 style sequencing controller: fetch/decode/execute/memory/writeback FSM with
// wait counting and a sticky fault flag. Define LC3_CTRL_TIMEOUT_EN to enable memory timeouts.
module lc3_seq_controller #(
    parameter int MAX_WAIT = 255,
    parameter int WAIT_W   = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [5:0]        C_Control,
    input  logic              complete,
    input  logic              stall,
    output logic [3:0]        state,
    output logic              enable_updatePC,
    output logic              enable_fetch,
    output logic              enable_decode,
    output logic              enable_execute,
    output logic              enable_writeback,
    output logic              mem_req,
    output logic              halted,
    output logic              error,
    output logic [WAIT_W-1:0] wait_count
);

    typedef enum logic [3:0] {
        S_UPDATE_PC = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_EXEC_ALU  = 4'd3,
        S_TARGET_PC = 4'd4,
        S_MEM_ADDR  = 4'd5,
        S_IND_READ  = 4'd6,
        S_READ_MEM  = 4'd7,
        S_WRITE_MEM = 4'd8,
        S_WRITEBACK = 4'd9,
        S_HALT      = 4'd10,
        S_INVALID   = 4'd15
    } state_t;

`ifdef LC3_CTRL_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    state_t            r_state;
    logic              r_error;
    logic [WAIT_W-1:0] r_wait;

    logic       w_load;
    logic [1:0] w_mam;
    logic       w_store_pc;
    logic [1:0] w_instr_type;
    logic       w_is_mem;
    logic       w_timeout;

    assign w_load       = C_Control[0];
    assign w_mam        = C_Control[2:1];
    assign w_store_pc   = C_Control[3];
    assign w_instr_type = C_Control[5:4];

    assign w_is_mem  = (r_state == S_FETCH) || (r_state == S_IND_READ) ||
                       (r_state == S_READ_MEM) || (r_state == S_WRITE_MEM);
    assign w_timeout = TIMEOUT_EN && (r_wait == WAIT_W'(MAX_WAIT));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_wait  <= '0;
            r_error <= 1'b0;
        end else begin
            // NOTE: non-blocking defaults; a later assignment in this block wins.
            r_wait <= '0;
            if (w_is_mem && !complete) begin
                if (w_timeout) begin
                    r_state <= S_INVALID;
                    r_error <= 1'b1;
                end else if (r_wait != {WAIT_W{1'b1}}) begin
                    r_wait <= r_wait + WAIT_W'(1);
                end else begin
                    r_wait <= r_wait;
                end
            end else begin
                case (r_state)
                    S_UPDATE_PC: if (!stall) r_state <= S_FETCH;
                    S_FETCH:     r_state <= S_DECODE;
                    S_DECODE:
                        if (!stall) begin
                            case (w_instr_type)
                                2'd0:    r_state <= S_EXEC_ALU;
                                2'd1:    r_state <= S_TARGET_PC;
                                2'd2:    r_state <= S_MEM_ADDR;
                                default: r_state <= S_HALT;
                            endcase
                        end
                    S_EXEC_ALU:  if (!stall) r_state <= S_WRITEBACK;
                    S_TARGET_PC: if (!stall) r_state <= w_store_pc ? S_WRITEBACK : S_UPDATE_PC;
                    S_MEM_ADDR:
                        if (!stall) begin
                            case (w_mam)
                                2'd0:    r_state <= S_IND_READ;
                                2'd1:    r_state <= S_READ_MEM;
                                2'd2:    r_state <= S_WRITE_MEM;
                                default: r_state <= S_WRITEBACK;
                            endcase
                        end
                    S_IND_READ:  r_state <= w_load ? S_READ_MEM : S_WRITE_MEM;
                    S_READ_MEM:  r_state <= S_WRITEBACK;
                    S_WRITE_MEM: r_state <= S_UPDATE_PC;
                    S_WRITEBACK: if (!stall) r_state <= S_UPDATE_PC;
                    S_HALT:      r_state <= S_HALT;
                    S_INVALID: begin
                        r_state <= S_INVALID;
                        r_error <= 1'b1;
                    end
                    // Encodings 11..14 are illegal and trap into the fault state.
                    default: begin
                        r_state <= S_INVALID;
                        r_error <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign state            = r_state;
    assign wait_count       = r_wait;
    assign error            = r_error;
    assign mem_req          = w_is_mem;
    assign halted           = (r_state == S_HALT);
    assign enable_updatePC  = (r_state == S_UPDATE_PC);
    assign enable_fetch     = (r_state == S_FETCH);
    assign enable_decode    = (r_state == S_DECODE);
    assign enable_execute   = (r_state == S_EXEC_ALU) || (r_state == S_TARGET_PC) ||
                              (r_state == S_MEM_ADDR);
    assign enable_writeback = (r_state == S_WRITEBACK);

endmodule

// File: tb/tb_lc3_seq_controller.sv
// Self-checking bench for lc3_seq_controller: directed sequences plus randomized
// stimulus compared against a behavioural model. Honours LC3_CTRL_TIMEOUT_EN.
module tb_lc3_seq_controller;

    localparam int MAX_WAIT = 4;
    localparam int WAIT_W   = 8;
    localparam int SAT      = (1 << WAIT_W) - 1;

`ifdef LC3_CTRL_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [5:0]        C_Control = '0;
    logic              complete = 1'b0;
    logic              stall = 1'b0;
    logic [3:0]        state;
    logic              enable_updatePC, enable_fetch, enable_decode;
    logic              enable_execute, enable_writeback;
    logic              mem_req, halted, error;
    logic [WAIT_W-1:0] wait_count;

    lc3_seq_controller #(.MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)) dut (
        .clock            (clock),
        .reset            (reset),
        .C_Control        (C_Control),
        .complete         (complete),
        .stall            (stall),
        .state            (state),
        .enable_updatePC  (enable_updatePC),
        .enable_fetch     (enable_fetch),
        .enable_decode    (enable_decode),
        .enable_execute   (enable_execute),
        .enable_writeback (enable_writeback),
        .mem_req          (mem_req),
        .halted           (halted),
        .error            (error),
        .wait_count       (wait_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int m_state;
    int m_wait;
    bit m_err;
    int dec_tbl[4] = '{3, 4, 5, 10};
    int mam_tbl[4] = '{6, 7, 8, 9};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] exp_en(input int s);
        // {updatePC, fetch, decode, execute, writeback}
        if (s == 0) return 5'b10000;
        if (s == 1) return 5'b01000;
        if (s == 2) return 5'b00100;
        if (s >= 3 && s <= 5) return 5'b00010;
        if (s == 9) return 5'b00001;
        return 5'b00000;
    endfunction

    function automatic bit is_mem(input int s);
        return (s == 1) || (s == 6) || (s == 7) || (s == 8);
    endfunction

    task automatic model_reset();
        m_state = 1;
        m_wait  = 0;
        m_err   = 1'b0;
    endtask

    task automatic model_step(input logic [5:0] c, input logic cp, input logic st);
        int nxt;
        int nw;
        nxt = m_state;
        nw  = 0;
        if (is_mem(m_state)) begin
            if (cp) begin
                if (m_state == 1)      nxt = 2;
                else if (m_state == 6) nxt = c[0] ? 7 : 8;
                else if (m_state == 7) nxt = 9;
                else                   nxt = 0;
            end else if (TO_EN && m_wait == MAX_WAIT) begin
                nxt   = 15;
                m_err = 1'b1;
            end else begin
                nw = (m_wait < SAT) ? m_wait + 1 : SAT;
            end
        end else if (!st) begin
            if (m_state == 0)      nxt = 1;
            else if (m_state == 2) nxt = dec_tbl[c[5:4]];
            else if (m_state == 3) nxt = 9;
            else if (m_state == 4) nxt = c[3] ? 9 : 0;
            else if (m_state == 5) nxt = mam_tbl[c[2:1]];
            else if (m_state == 9) nxt = 0;
        end
        m_state = nxt;
        m_wait  = nw;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_state"}, 32'(state), 32'(m_state));
        check({tag, "_wait"}, 32'(wait_count), 32'(m_wait));
        check({tag, "_error"}, 32'(error), 32'(m_err));
        check({tag, "_halted"}, 32'(halted), 32'(m_state == 10));
        check({tag, "_memreq"}, 32'(mem_req), 32'(is_mem(m_state)));
        check({tag, "_en"}, 32'({enable_updatePC, enable_fetch, enable_decode,
                                 enable_execute, enable_writeback}), 32'(exp_en(m_state)));
    endtask

    // Called just after a rising edge; drives, clocks once, checks 1 time unit later.
    task automatic cycle(input logic [5:0] c, input logic cp, input logic st);
        C_Control = c;
        complete  = cp;
        stall     = st;
        @(posedge clock);
        model_step(c, cp, st);
        #1;
        check_all("cyc");
    endtask

    // Asserts reset mid-cycle and checks its effect before any clock edge.
    task automatic async_reset();
        #2 reset = 1'b1;
        model_reset();
        #1;
        check_all("arst");
        #1 reset = 1'b0;
    endtask

    task automatic seq(input string tag, input logic [5:0] c, input int q[$]);
        foreach (q[i]) begin
            cycle(c, 1'b1, 1'b0);
            check(tag, 32'(state), 32'(q[i]));
        end
    endtask

    initial begin
        int q[$];
        int cp_bias;
        logic [5:0] rc;

        model_reset();
        #12;
        check_all("por");
        #1 reset = 1'b0;

        q = {2, 3, 9, 0, 1};
        seq("alu_seq", 6'b000000, q);
        q = {2, 4, 9, 0, 1};
        seq("jsr_seq", 6'b011000, q);
        q = {2, 4, 0, 1};
        seq("br_seq", 6'b010000, q);

        q = {2, 5, 6};
        seq("ind_seq", 6'b100001, q);
        for (int i = 0; i < 3; i++) begin
            cycle(6'b100001, 1'b0, 1'b0);
            check("ind_wait", 32'(wait_count), 32'(i + 1));
            check("ind_hold", 32'(state), 32'd6);
        end
        cycle(6'b100001, 1'b1, 1'b0);
        check("ind_to_read", 32'(state), 32'd7);
        check("ind_wait_clr", 32'(wait_count), 32'd0);
        cycle(6'b100001, 1'b1, 1'b0);
        check("read_to_wb", 32'(state), 32'd9);
        cycle(6'b100001, 1'b1, 1'b0);
        cycle(6'b100001, 1'b1, 1'b0);

        cycle(6'b100010, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(6'b100010, 1'b1, 1'b1);
            check("stall_decode", 32'(state), 32'd2);
        end
        cycle(6'b100010, 1'b1, 1'b0);
        cycle(6'b100010, 1'b1, 1'b0);
        check("ld_read", 32'(state), 32'd7);
        cycle(6'b100010, 1'b1, 1'b1);
        check("stall_ignored_mem", 32'(state), 32'd9);
        cycle(6'b100010, 1'b1, 1'b0);
        cycle(6'b100010, 1'b1, 1'b0);

        // Long wait in Fetch: timeout to Invalid, or saturation without the timeout build.
        for (int i = 0; i < 300; i++) cycle(6'b000000, 1'b0, 1'b0);
        if (TO_EN) begin
            check("timeout_state", 32'(state), 32'd15);
            check("timeout_error", 32'(error), 32'd1);
        end else begin
            check("sat_state", 32'(state), 32'd1);
            check("sat_wait", 32'(wait_count), 32'(SAT));
        end
        async_reset();
        check("rst_err_clr", 32'(error), 32'd0);

        q = {2, 10};
        seq("halt_seq", 6'b110000, q);
        for (int i = 0; i < 20; i++) begin
            cycle(6'($urandom), 1'($urandom), 1'($urandom));
            check("halt_hold", 32'(halted), 32'd1);
        end
        async_reset();
        check("halt_rst", 32'(state), 32'd1);

        cp_bias = 2;
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) cp_bias = $urandom_range(0, 4);
            rc = 6'($urandom);
            cycle(rc, ($urandom_range(0, 4) < cp_bias), ($urandom_range(0, 3) == 0));
            if ((m_state == 10 || m_state == 15) && $urandom_range(0, 7) == 0)
                async_reset();
            else if ($urandom_range(0, 99) == 0)
                async_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lc3_seq_controller.md
LC3_SEQ_CONTROLLER -- requirements
Module: lc3_seq_controller

Interface
REQ-001 Parameter MAX_WAIT, 255: maximum cycles any memory state may wait for complete before timeout.
REQ-002 Parameter WAIT_W, 8: width of the wait counter; MAX_WAIT SHALL fit in WAIT_W bits.
REQ-003 Port clock  in  1  single system clock, all state updates on rising edge.
REQ-004 Port reset  in  1  asynchronous, active-high reset.
REQ-005 Port C_Control  in  6  [0] Load, [2:1] MAM, [3] storePC, [5:4] instrType.
REQ-006 Port complete  in  1  memory transaction done, sampled on rising edge.
REQ-007 Port stall  in  1  hold request; freezes the FSM in non-memory states.
REQ-008 Port state  out  4  current state encoding.
REQ-009 Port enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback  out  1 each  one-hot unit enables.
REQ-010 Port mem_req  out  1  memory access in progress.
REQ-011 Port halted  out  1  HALT state reached.
REQ-012 Port error  out  1  sticky fault flag.
REQ-013 Port wait_count  out  WAIT_W  cycles spent in the current memory state.

Function
REQ-014 State encoding: 0 UpdatePC, 1 Fetch, 2 Decode, 3 ExecALU, 4 TargetPC, 5 MemAddr, 6 IndirectRead, 7 ReadMem, 8 WriteMem, 9 WriteBack, 10 Halt, 15 Invalid.
REQ-015 Transitions: 0->1; 1->2 on complete; 2->3/4/5/10 for instrType 0/1/2/3; 3->9; 4->9 if storePC else 0; 5->6/7/8/9 for MAM 0/1/2/3; 6->7 if Load else 8, on complete; 7->9 on complete; 8->0 on complete; 9->0.
REQ-016 Halt (10) SHALL be held until reset; halted=1 only in state 10.
REQ-017 Invalid (15) SHALL be held until reset; error=1 on entry and remains 1 until reset.
REQ-018 Any unlisted state value SHALL transition to 15.
REQ-019 stall=1 in states 0, 2, 3, 4, 5 or 9 SHALL hold the state; stall SHALL be ignored in memory states 1, 6, 7 and 8.
REQ-020 mem_req SHALL be 1 exactly in states 1, 6, 7 and 8, decoded from the state register.
REQ-021 Enables decoded from state: updatePC in 0, fetch in 1, decode in 2, execute in 3, 4 and 5, writeback in 9; all other states drive all enables 0.
REQ-022 wait_count SHALL increment each cycle a memory state is held with complete=0; it SHALL clear to 0 on every state change and on complete=1.
REQ-023 wait_count SHALL saturate at its maximum value and never wrap.
REQ-024 complete=1 in the same cycle as a timeout condition SHALL take the complete transition.

Reset
REQ-025 Asserting reset SHALL immediately, without waiting for clock, set state=1, wait_count=0 and error=0, including mid-transaction.
REQ-026 After reset the outputs SHALL be enable_fetch=1, mem_req=1, every other enable=0, halted=0.

Configuration
REQ-027 Macro LC3_CTRL_TIMEOUT_EN defined: in a memory state with wait_count==MAX_WAIT and complete=0, the next edge SHALL go to 15 and set error.
REQ-028 Macro LC3_CTRL_TIMEOUT_EN undefined: memory states SHALL wait indefinitely, wait_count still counts and saturates, and timeout SHALL never set error.

Verification
REQ-029 Reset, C_Control=6'b000000, complete=1 -> state sequence 1,2,3,9,0,1 on consecutive edges.
REQ-030 C_Control=6'b011000, complete=1 -> 1,2,4,9,0; then 6'b010000 -> 1,2,4,0.
REQ-031 C_Control=6'b100001 (MAM=0, Load=1), complete held 0 for 3 cycles in state 6 -> wait_count 1,2,3, then complete=1 -> 7 with wait_count=0, then 9.
REQ-032 C_Control=6'b110000 -> 1,2,10, halted=1 held for 20 cycles; reset -> state 1 asynchronously.
REQ-033 LC3_CTRL_TIMEOUT_EN defined, MAX_WAIT=4, complete=0 in state 1 -> state 15 after 5 edges with error=1; macro undefined -> stays in 1 and wait_count saturates at 255.
REQ-034 stall=1 in state 2 for 3 cycles -> state held at 2; stall=1 in state 7 -> complete still moves the FSM to 9.
